rsa_decrypt_core: RTL and testbench

RSA_DECRYPT_CORE -- requirements
Module: rsa_decrypt_core

---
 rtl/rsa_decrypt_core_pkg.sv | 15 +
 rtl/rsa_decrypt_core_modmul.sv | 65 ++++++
 rtl/rsa_decrypt_core.sv | 112 +++++++++++
 tb/tb_rsa_decrypt_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_decrypt_core_pkg.sv
// Shared definitions for the RSA modular-exponentiation cores and their benches.
// Holds the default operand width and the sequencer state encoding.
package rsa_decrypt_core_pkg;

    localparam int BITS = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        SQR   = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/rsa_decrypt_core_modmul.sv
// Bit-serial MSB-first shift-add modular multiplier: p = a*b mod n in BITS cycles.
// The step taken in the go cycle uses the live inputs, so the result appears on p with rdy=1 in the BITS-th cycle.
module modmul_serial #(
    parameter int BITS = rsa_decrypt_core_pkg::BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] p,
    output logic            rdy
);

    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    logic            active;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] p_q, md_q, mr_q, n_q;

    logic [BITS-1:0] cur_p, cur_md, cur_n, dbl_red;
    logic            cur_bit;
    logic [CW-1:0]   idx;
    logic [BITS:0]   dbl, sum;

    // Operands fit in BITS bits, so one conditional subtract suffices after each doubling or add.
    always_comb begin
        cur_p   = go ? '0 : p_q;
        cur_md  = go ? a : md_q;
        cur_n   = go ? n : n_q;
        cur_bit = go ? b[BITS-1] : mr_q[BITS-1];
        idx     = go ? '0 : cnt;
        dbl     = {cur_p, 1'b0};
        dbl_red = (dbl >= {1'b0, cur_n}) ? BITS'(dbl - {1'b0, cur_n}) : BITS'(dbl);
        sum     = cur_bit ? ({1'b0, dbl_red} + {1'b0, cur_md}) : {1'b0, dbl_red};
        p       = (sum >= {1'b0, cur_n}) ? BITS'(sum - {1'b0, cur_n}) : BITS'(sum);
        rdy     = (go || active) && (idx == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            p_q    <= '0;
            md_q   <= '0;
            mr_q   <= '0;
            n_q    <= '0;
        end else if (go) begin
            active <= 1'(BITS > 1);
            cnt    <= CW'(1);
            p_q    <= p;
            md_q   <= a;
            mr_q   <= b << 1;
            n_q    <= n;
        end else if (active) begin
            cnt    <= cnt + CW'(1);
            p_q    <= p;
            mr_q   <= mr_q << 1;
            if (cnt == LAST) active <= 1'b0;
        end
    end

endmodule

// File: rtl/rsa_decrypt_core.sv
// RSA decrypt/encrypt core: r = c^e mod n by right-to-left square-and-multiply.
// Multiplies run back to back on one serial modular multiplier sequenced only by this FSM.
module rsa_decrypt_core #(
    parameter int BITS = rsa_decrypt_core_pkg::BITS
) (
    input  logic            sysclk,
    input  logic            sysreset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [BITS-1:0] c,
    input  logic [BITS-1:0] e,
    input  logic [BITS-1:0] n,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [BITS-1:0] r
);

    import rsa_decrypt_core_pkg::*;

    state_t          state, state_d;
    logic [BITS-1:0] c_q, e_q, n_q, acc, base;
    logic            go_q, go_d;
    logic            bad_ops, exp_last, abort_now;
    logic [BITS-1:0] mm_a, mm_p;
    logic            mm_rdy;

    modmul_serial #(.BITS(BITS)) u_modmul (
        .clk   (sysclk),
        .rst_n (sysreset_n),
        .go    (go_q),
        .a     (mm_a),
        .b     (base),
        .n     (n_q),
        .p     (mm_p),
        .rdy   (mm_rdy)
    );

    always_comb begin
        state_d   = state;
        bad_ops   = (n_q < BITS'(2)) || (c_q >= n_q);
        exp_last  = (e_q[BITS-1:1] == '0);
        abort_now = abort && (state != IDLE);
        mm_a      = (state == MUL) ? acc : base;
        unique case (state)
            IDLE:    if (start) state_d = CHECK;
            CHECK: begin
                if (bad_ops || (e_q == '0)) state_d = FIN;
                else                        state_d = e_q[0] ? MUL : SQR;
            end
            MUL:     if (mm_rdy) state_d = exp_last ? FIN : SQR;
            SQR:     if (mm_rdy) state_d = e_q[1] ? MUL : SQR;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides any transition, including one completing this cycle.
        if (abort_now) state_d = IDLE;
        go_d = ((state_d == MUL) || (state_d == SQR)) &&
               ((state == CHECK) || (((state == MUL) || (state == SQR)) && mm_rdy));
        busy = (state != IDLE);
        done = (state == FIN);
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) state <= IDLE;
        else             state <= state_d;
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            go_q <= 1'b0;
            c_q  <= '0;
            e_q  <= '0;
            n_q  <= '0;
            acc  <= '0;
            base <= '0;
            r    <= '0;
            err  <= 1'b0;
        end else begin
            go_q <= go_d;
            unique case (state)
                IDLE: if (start) begin
                    c_q <= c;
                    e_q <= e;
                    n_q <= n;
                    err <= 1'b0;
                end
                CHECK: if (!abort_now) begin
                    if (bad_ops) begin
                        r   <= '0;
                        err <= 1'b1;
                    end else if (e_q == '0) begin
                        r <= BITS'(1);
                    end else begin
                        acc  <= BITS'(1);
                        base <= c_q;
                    end
                end
                MUL: if (mm_rdy && !abort_now) begin
                    acc <= mm_p;
                    if (exp_last) r <= mm_p;
                end
                SQR: if (mm_rdy && !abort_now) begin
                    base <= mm_p;
                    e_q  <= e_q >> 1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// Scoreboard bench for rsa_decrypt_core: a driver issues operations and queues expected results,
// a monitor compares every done pulse against a plain-arithmetic modular-exponentiation model.
module tb_rsa_decrypt_core;

    import rsa_decrypt_core_pkg::*;

    logic            sysclk, sysreset_n, start, abort;
    logic [BITS-1:0] c, e, n;
    logic            busy, done, err;
    logic [BITS-1:0] r;

    rsa_decrypt_core #(.BITS(BITS)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .start      (start),
        .abort      (abort),
        .c          (c),
        .e          (e),
        .n          (n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .r          (r)
    );

    typedef struct {
        logic [31:0] r;
        logic        err;
        int          start_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        int          tag;
        logic [31:0] act;
        logic [31:0] exp_v;
    } chk_t;

    exp_t        sb_q[$];
    chk_t        chk_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] last_r;
    logic        last_err;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic string tag_name(input int tag);
        case (tag)
            0:  return "reset_r";
            1:  return "reset_err";
            2:  return "reset_busy";
            3:  return "reset_done";
            4:  return "busy_after_start";
            5:  return "abort_busy";
            6:  return "abort_r_hold";
            7:  return "abort_err_hold";
            8:  return "done_timeout";
            9:  return "midrst_busy";
            10: return "midrst_done";
            11: return "midrst_r";
            12: return "midrst_err";
            13: return "start_in_fin_ignored";
            default: return "unknown";
        endcase
    endfunction

    // Reference: left-to-right binary exponentiation on 64-bit integers.
    function automatic exp_t model(input logic [31:0] cc, input logic [31:0] ee, input logic [31:0] nn);
        exp_t        m;
        logic [63:0] a64, n64, c64;
        int          msb;
        m.r = 32'd0; m.err = 1'b0; m.lat = 2; m.start_cyc = 0;
        if (nn < 32'd2 || cc >= nn) begin
            m.err = 1'b1;
            return m;
        end
        if (ee == 32'd0) begin
            m.r = 32'd1;
            return m;
        end
        n64 = {32'd0, nn};
        c64 = {32'd0, cc};
        a64 = 64'd1;
        msb = 0;
        for (int i = 31; i >= 0; i--) begin
            a64 = (a64 * a64) % n64;
            if (ee[i]) a64 = (a64 * c64) % n64;
        end
        for (int i = 0; i < 32; i++) if (ee[i]) msb = i;
        m.r   = a64[31:0];
        m.lat = 2 + 32 * ($countones(ee) + msb);
        return m;
    endfunction

    task automatic post(input int tag, input logic [31:0] act, input logic [31:0] ev);
        chk_t k;
        k.tag = tag; k.act = act; k.exp_v = ev;
        chk_q.push_back(k);
    endtask

    task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] ev);
        vectors++;
        if (act !== ev) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d", nm, act, act, ev, ev, cyc);
        end
    endtask

    // Monitor: drains queued direct checks and scores every done pulse.
    initial begin
        exp_t x;
        chk_t k;
        forever begin
            @(negedge sysclk);
            while (chk_q.size() > 0) begin
                k = chk_q.pop_front();
                compare(tag_name(k.tag), k.act, k.exp_v);
            end
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    compare("unexpected_done", 32'd1, 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    compare("result_r", r, x.r);
                    compare("result_err", {31'd0, err}, {31'd0, x.err});
                    compare("latency", 32'(cyc - x.start_cyc), 32'(x.lat));
                end
            end
        end
    end

    task automatic issue_op(input logic [31:0] cc, input logic [31:0] ee, input logic [31:0] nn,
                            input bit use_k, input logic [31:0] kr, input logic kerr,
                            output exp_t x);
        @(posedge sysclk); #1;
        c = cc; e = ee; n = nn; start = 1'b1;
        x = model(cc, ee, nn);
        if (use_k) begin
            x.r = kr; x.err = kerr;
        end
        x.start_cyc = cyc;
        sb_q.push_back(x);
        last_r = x.r; last_err = x.err;
        @(posedge sysclk); #1;
        start = 1'b0;
        post(4, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < 2200) begin
            @(posedge sysclk);
            i++;
        end
        if (sb_q.size() != 0) begin
            post(8, 32'd1, 32'd0);
            sb_q.delete();
        end
        @(negedge sysclk); #1;
    endtask

    task automatic run_op(input logic [31:0] cc, input logic [31:0] ee, input logic [31:0] nn,
                          input bit use_k, input logic [31:0] kr, input logic kerr);
        exp_t x;
        issue_op(cc, ee, nn, use_k, kr, kerr, x);
        wait_drain();
    endtask

    initial begin
        exp_t        x;
        logic [31:0] rc, re, rn;
        sysreset_n = 1'b0; start = 1'b0; abort = 1'b0;
        c = '0; e = '0; n = '0;
        last_r = '0; last_err = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        post(0, r, 32'd0);
        post(1, {31'd0, err}, 32'd0);
        post(2, {31'd0, busy}, 32'd0);
        post(3, {31'd0, done}, 32'd0);
        sysreset_n = 1'b1;

        // Known RSA pair, boundary operands and operand errors.
        run_op(32'd2790, 32'd2753, 32'd3233, 1'b1, 32'd65, 1'b0);
        run_op(32'd2, 32'hFFFFFFFA, 32'hFFFFFFFB, 1'b1, 32'd1, 1'b0);
        run_op(32'd0, 32'd5, 32'd11, 1'b1, 32'd0, 1'b0);
        run_op(32'd7, 32'd0, 32'd11, 1'b1, 32'd1, 1'b0);
        run_op(32'd5, 32'd3, 32'd1, 1'b1, 32'd0, 1'b1);
        run_op(32'd3233, 32'd7, 32'd3233, 1'b1, 32'd0, 1'b1);
        run_op(32'd65, 32'd17, 32'd3233, 1'b1, 32'd2790, 1'b0);

        // Abort 100 cycles into a decrypt, then restart it.
        @(posedge sysclk); #1;
        c = 32'd2790; e = 32'd2753; n = 32'd3233; start = 1'b1;
        @(posedge sysclk); #1;
        start = 1'b0;
        repeat (99) @(posedge sysclk);
        #1 abort = 1'b1;
        @(posedge sysclk); #1;
        abort = 1'b0;
        post(5, {31'd0, busy}, 32'd0);
        post(6, r, last_r);
        post(7, {31'd0, err}, 32'd0);
        repeat (700) @(posedge sysclk);
        run_op(32'd2790, 32'd2753, 32'd3233, 1'b1, 32'd65, 1'b0);

        // start while busy and in FIN is ignored; operand changes after start have no effect.
        issue_op(32'd1234, 32'd77, 32'd3233, 1'b0, 32'd0, 1'b0, x);
        repeat (20) @(posedge sysclk);
        #1 start = 1'b1; c = 32'd9; e = 32'd3; n = 32'd13;
        @(posedge sysclk); #1;
        start = 1'b0; c = 32'd1; e = 32'd1; n = 32'd2;
        while (cyc < x.start_cyc + x.lat) begin
            @(posedge sysclk); #1;
        end
        start = 1'b1; c = 32'd4; e = 32'd5; n = 32'd7;
        @(posedge sysclk); #1;
        start = 1'b0;
        post(13, {31'd0, busy}, 32'd0);
        wait_drain();

        // Randomized operands against the model.
        for (int i = 0; i < 12; i++) begin
            rn = $urandom;
            if (i % 4 == 3) rn = $urandom_range(2, 1000);
            if (rn < 32'd2) rn = 32'd2;
            rc = $urandom % rn;
            re = $urandom;
            if (i % 6 == 0) rc = rn + 32'(i % 2);
            if (i % 6 == 1) re = 32'd0;
            if (i % 6 == 2) re = $urandom_range(1, 255);
            if (rc < rn || i % 6 == 0) run_op(rc, re, rn, 1'b0, 32'd0, 1'b0);
        end

        // Reset pulsed mid-operation: outputs clear at once and no done follows.
        @(posedge sysclk); #1;
        c = 32'd2790; e = 32'd2753; n = 32'd3233; start = 1'b1;
        @(posedge sysclk); #1;
        start = 1'b0;
        repeat (40) @(posedge sysclk);
        #3 sysreset_n = 1'b0;
        #1;
        post(9, {31'd0, busy}, 32'd0);
        post(10, {31'd0, done}, 32'd0);
        post(11, r, 32'd0);
        post(12, {31'd0, err}, 32'd0);
        @(posedge sysclk); #1;
        sysreset_n = 1'b1;
        repeat (100) @(posedge sysclk);
        run_op(32'd65, 32'd17, 32'd3233, 1'b1, 32'd2790, 1'b0);

        repeat (3) @(posedge sysclk);
        @(negedge sysclk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
